prog_loader: RTL
================

// Module: prog_loader
// PURPOSE
//  Upstream boot stage for the accumulator CPU. Receives a framed program image as a byte
//  stream and writes it into the 32x8 instruction memory that the CPU fetches from. Holds
//  the CPU in reset until the image is completely written (and, optionally, verified).
//  Sits between the host byte link and the CPU's instruction memory write port / reset input.
// PARAMETERS
//  ADDR_W     5       instruction memory address width; DEPTH = 1<<ADDR_W words
//  DATA_W     8       instruction/byte width
//  SYNC_BYTE  8'hA5   frame start marker
// PORTS
//  clk_i          in   1       system clock; one clock domain
//  rst_ni         in   1       reset, asynchronous, active-low
//  byte_i         in   DATA_W  incoming stream byte
//  byte_valid_i   in   1       byte_i valid
//  byte_ready_o   out  1       loader can accept; transfer = valid & ready on rising clk_i
//  start_i        in   1       pulse: re-arm loader from DONE/ERR
//  imem_we_o      out  1       instruction memory write strobe (registered)
//  imem_addr_o    out  ADDR_W  write address (registered)
//  imem_data_o    out  DATA_W  write data (registered)
//  cpu_rst_o      out  1       active-high reset to CPU; 1 while loading
//  done_o         out  1       image loaded, CPU released
//  err_o          out  1       frame error (bad length / checksum)
//  count_o        out  ADDR_W+1 words written in current frame
// BEHAVIOUR
//  - Reset (rst_ni=0, async): state SYNC; imem_we_o=0, imem_addr_o=0, imem_data_o=0,
//    cpu_rst_o=1, done_o=0, err_o=0, count_o=0. Reset mid-frame aborts; no further writes.
//  - Frame: SYNC_BYTE, LEN (1..DEPTH), LEN data bytes [, CSUM when LOADER_CHECKSUM_EN].
//  - FSM: SYNC -> LEN on accepted SYNC_BYTE; other bytes accepted and discarded.
//    LEN: LEN==0 or LEN>DEPTH -> ERR; else latch LEN, count_o=0 -> DATA.
//    DATA: each accepted byte -> next cycle imem_we_o=1, addr=count_o, data=byte; count_o++.
//    Last data byte -> DONE (or CSUM). CSUM: match -> DONE, mismatch -> ERR.
//    DONE/ERR: byte_ready_o=0; start_i=1 -> SYNC next edge, cpu_rst_o=1, done_o/err_o=0.
//    start_i ignored in SYNC/LEN/DATA/CSUM.
//  - byte_ready_o = 1 in SYNC, LEN, DATA, CSUM (Moore, no comb path from byte_valid_i).
//  - Latency: accepted data byte at edge k -> imem_we_o high for cycle k..k+1 (one cycle).
//  - cpu_rst_o falls and done_o rises on the edge after the final imem_we_o pulse, so the CPU
//    never fetches from a partially written memory. ERR keeps cpu_rst_o=1, err_o=1.
//  - LEN==DEPTH (32) legal; count_o is ADDR_W+1 bits so it reaches DEPTH without wrap;
//    imem_addr_o uses count_o[ADDR_W-1:0]. Words beyond LEN keep previous contents.
//  - byte_valid_i gaps at any point only stall the FSM; no timeout.
// CONFIGURATION
//  LOADER_CHECKSUM_EN defined: CSUM state present; CSUM byte must equal 8-bit sum (mod 256)
//    of the LEN data bytes; mismatch -> ERR, no CPU release (data already written stays).
//  Undefined: no CSUM state, DATA -> DONE directly; err_o only for bad LEN.
// STRUCTURE
//  Shared header loader_defs.vh: state encodings (SYNC, LEN, DATA, CSUM, DONE, ERR),
//    default SYNC_BYTE, DEPTH derivation; shared with the bench.
//  One sub-module: ld_csum (clear/accumulate 8-bit running sum, compare output), instanced
//    only under LOADER_CHECKSUM_EN.
// TESTING
//  1. rst_ni=0 -> cpu_rst_o=1, byte_ready_o=1, imem_we_o=0, done_o=0, err_o=0, count_o=0.
//  2. Stream A5,03,11,22,33 (no checksum) -> writes 0:11, 1:22, 2:33; edge after last write
//     done_o=1, cpu_rst_o=0, byte_ready_o=0, count_o=3.
//  3. With LOADER_CHECKSUM_EN: A5,02,10,20,30 -> done_o=1; A5,02,10,20,31 -> err_o=1,
//     cpu_rst_o=1.
//  4. A5,00 and A5,21 -> err_o=1, zero write strobes; A5,20 + 32 bytes -> addr 0..31, done.
//  5. Leading 00,FF,5A before A5 discarded; random byte_valid_i gaps -> identical writes.
//  6. rst_ni low after 2 data bytes -> SYNC, cpu_rst_o=1, no more writes; start_i in DONE ->
//     SYNC, cpu_rst_o=1, second image loads.

Source files
------------

// File: rtl/prog_loader_pkg.sv
// Shared definitions for the program loader: sizes, frame marker, FSM states.
// Optional checksum stage is enabled by defining LOADER_CHECKSUM_EN.
package prog_loader_pkg;

   localparam int unsigned LD_ADDR_W = 5;
   localparam int unsigned LD_DATA_W = 8;
   localparam int unsigned LD_DEPTH  = 1 << LD_ADDR_W;
   localparam logic [7:0]  LD_SYNC_BYTE = 8'hA5;

   typedef enum logic [2:0] {
      ST_SYNC = 3'd0,
      ST_LEN  = 3'd1,
      ST_DATA = 3'd2,
      ST_CSUM = 3'd3,
      ST_DONE = 3'd4,
      ST_ERR  = 3'd5
   } ld_state_e;

   // States in which the loader takes bytes from the link.
   function automatic logic ld_accepts(input ld_state_e s);
      return (s == ST_SYNC) || (s == ST_LEN) || (s == ST_DATA) || (s == ST_CSUM);
   endfunction

endpackage

// File: rtl/ld_csum.sv
// Running 8-bit modular sum of a frame's data bytes with a compare against the
// trailing checksum byte. Used only when LOADER_CHECKSUM_EN is defined.
module ld_csum #(
   parameter int unsigned DATA_W = 8
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              clr_i,
   input  logic              acc_i,
   input  logic [DATA_W-1:0] byte_i,
   output logic              match_c
);

   logic [DATA_W-1:0] sum_q, sum_d;

   // Clear at frame start, add each accepted data byte.
   always_comb begin
      sum_d = sum_q;
      if (clr_i) begin
         sum_d = '0;
      end else if (acc_i) begin
         sum_d = DATA_W'(sum_q + byte_i);
      end
   end

   // Sum register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sum_q <= '0;
      end else begin
         sum_q <= sum_d;
      end
   end

   assign match_c = (sum_q == byte_i);

endmodule

// File: rtl/prog_loader.sv
// Boot-stage loader: parses SYNC/LEN/DATA[/CSUM] frames from a byte link, writes
// the image into instruction memory and holds the CPU in reset until it is complete.
// Define LOADER_CHECKSUM_EN to require a trailing modular-sum checksum byte.
module prog_loader
   import prog_loader_pkg::*;
#(
   parameter int unsigned       ADDR_W    = LD_ADDR_W,
   parameter int unsigned       DATA_W    = LD_DATA_W,
   parameter logic [DATA_W-1:0] SYNC_BYTE = DATA_W'(LD_SYNC_BYTE)
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic [DATA_W-1:0] byte_i,
   input  logic              byte_valid_i,
   output logic              byte_ready_o,
   input  logic              start_i,
   output logic              imem_we_o,
   output logic [ADDR_W-1:0] imem_addr_o,
   output logic [DATA_W-1:0] imem_data_o,
   output logic              cpu_rst_o,
   output logic              done_o,
   output logic              err_o,
   output logic [ADDR_W:0]   count_o
);

   localparam int unsigned       CNT_W   = ADDR_W + 1;
   localparam int unsigned       DEPTH   = 1 << ADDR_W;
   localparam logic [DATA_W-1:0] DEPTH_B = DATA_W'(DEPTH);

   ld_state_e         state_q, state_d;
   logic [CNT_W-1:0]  len_q, len_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              ready_q, ready_d;
   logic              cpu_rst_q, cpu_rst_d;
   logic              done_q, done_d;
   logic              err_q, err_d;
   logic              xfer_c;

   assign xfer_c = byte_valid_i && ready_q;

`ifdef LOADER_CHECKSUM_EN
   logic csum_clr_c, csum_acc_c, csum_ok_c;

   assign csum_clr_c = xfer_c && (state_q == ST_LEN);
   assign csum_acc_c = xfer_c && (state_q == ST_DATA);

   ld_csum #(
      .DATA_W (DATA_W)
   ) u_csum (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .clr_i   (csum_clr_c),
      .acc_i   (csum_acc_c),
      .byte_i  (byte_i),
      .match_c (csum_ok_c)
   );
`endif

   // Frame parser, memory write generation and release/error status.
   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      count_d = count_q;
      we_d    = 1'b0;
      addr_d  = addr_q;
      data_d  = data_q;

      case (state_q)
         ST_SYNC: begin
            if (xfer_c && (byte_i == SYNC_BYTE)) begin
               state_d = ST_LEN;
            end
         end
         ST_LEN: begin
            if (xfer_c) begin
               if ((byte_i == '0) || (byte_i > DEPTH_B)) begin
                  state_d = ST_ERR;
               end else begin
                  len_d   = CNT_W'(byte_i);
                  count_d = '0;
                  state_d = ST_DATA;
               end
            end
         end
         ST_DATA: begin
            if (xfer_c) begin
               we_d    = 1'b1;
               addr_d  = count_q[ADDR_W-1:0];
               data_d  = byte_i;
               count_d = CNT_W'(count_q + CNT_W'(1));
               if (count_d == len_q) begin
`ifdef LOADER_CHECKSUM_EN
                  state_d = ST_CSUM;
`else
                  state_d = ST_DONE;
`endif
               end
            end
         end
         ST_CSUM: begin
`ifdef LOADER_CHECKSUM_EN
            if (xfer_c) begin
               state_d = csum_ok_c ? ST_DONE : ST_ERR;
            end
`else
            state_d = ST_SYNC;
`endif
         end
         ST_DONE, ST_ERR: begin
            if (start_i) begin
               state_d = ST_SYNC;
            end
         end
         default: begin
            state_d = ST_SYNC;
         end
      endcase

      // Status lags entry into DONE by one edge so release follows the last write.
      done_d    = (state_q == ST_DONE) && !start_i;
      err_d     = (state_q == ST_ERR) && !start_i;
      cpu_rst_d = !done_d;
      ready_d   = ld_accepts(state_d);
   end

   // State and output registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= ST_SYNC;
         len_q     <= '0;
         count_q   <= '0;
         we_q      <= 1'b0;
         addr_q    <= '0;
         data_q    <= '0;
         ready_q   <= 1'b1;
         cpu_rst_q <= 1'b1;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         len_q     <= len_d;
         count_q   <= count_d;
         we_q      <= we_d;
         addr_q    <= addr_d;
         data_q    <= data_d;
         ready_q   <= ready_d;
         cpu_rst_q <= cpu_rst_d;
         done_q    <= done_d;
         err_q     <= err_d;
      end
   end

   assign byte_ready_o = ready_q;
   assign imem_we_o    = we_q;
   assign imem_addr_o  = addr_q;
   assign imem_data_o  = data_q;
   assign cpu_rst_o    = cpu_rst_q;
   assign done_o       = done_q;
   assign err_o        = err_q;
   assign count_o      = count_q;

endmodule
